// File: rtl/scanner_pkg.sv
// scanner_pkg: shared state encoding and sizing for the channel scanner
package scanner_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;
    localparam int NCH = 4;
    localparam int SEL_W = 2;
    localparam int CNT_W = 4;
endpackage

// File: rtl/dwell_counter.sv
// dwell_counter: counts hold cycles per channel, flags the terminal cycle
module dwell_counter
    import scanner_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] term,
    output logic             last
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign last = cnt_q == term;

    always_comb begin
        cnt_d = clear ? '0 : enable ? (last ? '0 : cnt_q + CNT_W'(1)) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/channel_scanner.sv
// channel_scanner: steps a 4-to-1 mux select, samples each channel, hands the word off
module channel_scanner
    import scanner_pkg::*;
#(
    parameter int DWELL = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [SEL_W-1:0] sel,
    input  logic             y,
    output logic [NCH-1:0]   word,
    output logic             valid,
    input  logic             ready,
    output logic             busy
);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DWELL - 1);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [NCH-1:0]   shadow_q, shadow_d;
    logic [NCH-1:0]   word_q, word_d;
    logic             dwell_last, step, last_ch;

    dwell_counter u_dwell (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_q != SCAN),
        .enable (state_q == SCAN),
        .term   (TERM),
        .last   (dwell_last)
    );

    assign step    = (state_q == SCAN) && dwell_last;
    assign last_ch = idx_q == SEL_W'(NCH - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            shadow_q <= '0;
            word_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            word_q   <= word_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? SCAN : IDLE;
            SCAN:    state_d = (step && last_ch) ? DONE : SCAN;
            DONE:    state_d = ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // the bit captured on the final edge goes straight into word alongside the shadow
    always_comb begin
        idx_d    = (state_q == SCAN) ? (step ? idx_q + SEL_W'(1) : idx_q) : '0;
        shadow_d = shadow_q;
        if (step) shadow_d[idx_q] = y;
        word_d   = (step && last_ch) ? shadow_d : word_q;
    end

    always_comb begin
        sel   = (state_q == SCAN) ? idx_q : '0;
        busy  = state_q == SCAN;
        valid = state_q == DONE;
        word  = word_q;
    end
endmodule

// File: tb/tb_channel_scanner.sv
// tb_channel_scanner: two scanners (DWELL 2 and 1) against a cycle-level scan model
module tb_channel_scanner;
    logic       clk = 1'b0;
    logic       rst_n, start, ready, cur;
    logic [3:0] a;
    logic [1:0] sel_a, sel_b;
    logic [3:0] word_a, word_b;
    logic       valid_a, valid_b, busy_a, busy_b, y_a, y_b;
    logic [7:0] obs;
    logic [3:0] exp_word [2];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    assign y_a = a[sel_a];
    assign y_b = a[sel_b];
    assign obs = cur ? {sel_b, busy_b, valid_b, word_b} : {sel_a, busy_a, valid_a, word_a};

    channel_scanner #(.DWELL(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start & ~cur), .sel(sel_a), .y(y_a),
        .word(word_a), .valid(valid_a), .ready(ready), .busy(busy_a)
    );

    channel_scanner #(.DWELL(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start & cur), .sel(sel_b), .y(y_b),
        .word(word_b), .valid(valid_b), .ready(ready), .busy(busy_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // obs layout: {sel[1:0], busy, valid, word[3:0]}
    task automatic run_scan(input bit which, input logic [3:0] a_val, input int rdy_delay,
                            input bit flip, input bit noise);
        int         dw;
        logic [3:0] nw;
        logic [7:0] exp;
        dw    = which ? 1 : 2;
        nw    = '0;
        cur   = which;
        a     = a_val;
        ready = (rdy_delay == 0);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 4 * dw; k++) begin
            exp = {2'(k / dw), 1'b1, 1'b0, exp_word[which]};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL scan dw=%0d k=%0d got %h want %h", dw, k, obs, exp);
            end
            if (flip && k / dw == 3 && k % dw == 0) a = ~a;
            if (k % dw == dw - 1) nw[k / dw] = a[k / dw];
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
        end
        exp_word[which] = nw;
        for (int k = 0; k <= rdy_delay; k++) begin
            exp = {2'b00, 1'b0, 1'b1, nw};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL done dw=%0d k=%0d got %h want %h", dw, k, obs, exp);
            end
            if (k == rdy_delay) begin
                ready = 1'b1;
                start = 1'b0;
            end else begin
                start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            step();
        end
        ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            exp = {2'b00, 1'b0, 1'b0, nw};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL idle dw=%0d k=%0d got %h want %h", dw, k, obs, exp);
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        ready = 1'b0;
        a     = '0;
        cur   = 1'b0;
        exp_word[0] = '0;
        exp_word[1] = '0;
        #1;
        for (int i = 0; i < 2; i++) begin
            cur = 1'(i);
            #1;
            checks++;
            if (obs !== 8'h00) begin
                errors++;
                $display("FAIL reset dut=%0d got %h want 00", i, obs);
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        cur = 1'b0;
        checks++;
        if (obs !== 8'h00) begin
            errors++;
            $display("FAIL post_reset got %h want 00", obs);
        end
    endtask

    task automatic test_basic();
        run_scan(1'b0, 4'b1010, 1, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_scan(1'b0, 4'b1101, 5, 1'b0, 1'b0);
    endtask

    task automatic test_dwell1();
        run_scan(1'b1, 4'b0110, 0, 1'b0, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_scan(1'b0, 4'($urandom), 3, 1'b0, 1'b1);
        run_scan(1'b1, 4'($urandom), 2, 1'b0, 1'b1);
    endtask

    task automatic test_mux_change();
        run_scan(1'b0, 4'b1010, 1, 1'b1, 1'b0);
    endtask

    task automatic test_mid_reset();
        bit seen_valid;
        cur   = 1'b0;
        a     = 4'b1010;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        checks++;
        if (obs[7:6] !== 2'd2 || obs[5] !== 1'b1) begin
            errors++;
            $display("FAIL mid_sel got %h want sel 2 busy 1", obs);
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp_word[0] = '0;
        exp_word[1] = '0;
        checks++;
        if (obs !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset got %h want 00", obs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (valid_a || busy_a) seen_valid = 1'b1;
        end
        checks++;
        if (seen_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_valid got %0b want 0", seen_valid);
        end
        run_scan(1'b0, 4'b1010, 1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++)
            run_scan(1'($urandom_range(0, 1)), 4'($urandom), $urandom_range(0, 4),
                     1'($urandom_range(0, 1)), 1'b1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_dwell1();
        test_start_ignored();
        test_mux_change();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/channel_scanner.md
CHANNEL_SCANNER -- requirements
Module: channel_scanner

Interface
REQ-001 The block SHALL have parameter DWELL, default 2, meaning cycles each channel is held before sampling (legal range 1..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request one 4-channel scan; sampled only in IDLE.
REQ-005 The block SHALL have port sel, output, 2 bits: channel select driven to the downstream 4-to-1 mux.
REQ-006 The block SHALL have port y, input, 1 bit: selected mux output (y = a[sel]).
REQ-007 The block SHALL have port word, output, 4 bits: assembled scan result, with word[i] = y sampled while sel = i.
REQ-008 The block SHALL have port valid, output, 1 bit: word holds a completed scan.
REQ-009 The block SHALL have port ready, input, 1 bit: consumer accepts word.
REQ-010 The block SHALL have port busy, output, 1 bit: a scan is in progress (SCAN state).

Function
REQ-011 The FSM SHALL have states IDLE, SCAN, DONE.
REQ-012 IDLE: sel = 0, busy = 0, valid = 0; start = 1 at edge E0 -> SCAN, channel index = 0, dwell count = 0.
REQ-013 SCAN: sel = channel index; dwell count increments each cycle; busy = 1.
REQ-014 In SCAN, at the edge where dwell count = DWELL-1, y SHALL be captured into shadow bit [index]; dwell count resets to 0 and index increments.
REQ-015 When the edge from REQ-014 occurs with index = 3, the shadow value (including the bit captured at that edge) SHALL load into word; state -> DONE; index wraps to 0.
REQ-016 valid SHALL first be high in the cycle after edge E0 + 4*DWELL (fixed latency 4*DWELL cycles from accepted start).
REQ-017 word SHALL change only on scan completion, and SHALL remain stable during a scan and while valid = 1.
REQ-018 DONE: valid = 1, sel = 0, busy = 0; valid & ready at an edge completes the transfer; state -> IDLE; valid = 0 next cycle.
REQ-019 If ready is already high when valid rises, the transfer SHALL complete in one cycle.
REQ-020 start SHALL be ignored in SCAN and DONE, with no queuing; a new scan requires start in IDLE.
REQ-021 With DWELL = 1, each channel SHALL be held exactly one cycle and y sampled at that cycle's edge.
REQ-022 The dwell counter SHALL be 4 bits wide and the index 2 bits wide; index wrap 3 -> 0 is modular.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, sel = 0, word = 0, valid = 0, busy = 0, index = 0, dwell count = 0, shadow = 0.
REQ-024 Reset mid-scan or in DONE SHALL abort with no valid pulse; the first start after release begins a fresh scan at channel 0.

Structure
REQ-025 A shared package scanner_pkg SHALL hold the state encoding (IDLE, SCAN, DONE), NCH = 4 and SEL_W = 2.
REQ-026 The dwell counter SHALL be a sub-module dwell_counter (inputs clk, rst_n, clear, enable, terminal value; output last).
REQ-027 The top level SHALL hold the FSM, channel index, shadow register and output registers.

Verification
REQ-028 DWELL = 2, bench mux a = 4'b1010, start pulse -> sel sequence 0,0,1,1,2,2,3,3; valid high 8 cycles after start edge; word = 4'b1010.
REQ-029 a = 4'b1101, ready held low for 5 cycles after valid -> valid and word = 4'b1101 held stable; ready = 1 -> valid drops next cycle; state IDLE.
REQ-030 DWELL = 1, a = 4'b0110, ready tied high -> word = 4'b0110, valid high exactly 1 cycle, 4-cycle latency.
REQ-031 Start pulsed again in SCAN and DONE -> no effect on sel sequence; exactly one valid per IDLE start.
REQ-032 rst_n low during channel 2 of a scan -> all outputs 0 immediately; no valid; following start with a = 4'b1010 yields word = 4'b1010.
REQ-033 a changes from 4'b1010 to 4'b0101 while sel = 3 (before its sample edge) -> word = 4'b0010 (bits 0..2 from 1010, bit 3 from 0101).
